// File: rtl/csi2tx_comp_byte_packer.sv
// Packs 6/7/8-bit compressed codes MSB-first into a CSI-2 RAW6/7/8 byte stream
// with zero padding of the final partial byte of each line.
module csi2tx_comp_byte_packer #(
  parameter int unsigned ACC_W = 16
) (
  input  logic       sensor_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic [4:0] comp_scheme,
  input  logic [7:0] enc_data,
  input  logic       enc_valid,
  input  logic       enc_last,
  output logic       enc_ready,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_last,
  input  logic       byte_ready,
  output logic       pad_err
);

  localparam int unsigned FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] FILL_BYTE = FILL_W'(8);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_e;

  function automatic logic [3:0] decode_width(input logic [4:0] scheme);
    logic [3:0] w;
    case (scheme)
      5'd2, 5'd5: w = 4'd7;
      5'd3, 5'd6: w = 4'd6;
      default:    w = 4'd8;
    endcase
    return w;
  endfunction

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [3:0]        width_q, width_d;
  logic              enc_ready_q, enc_ready_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              byte_valid_q, byte_valid_d;
  logic              byte_last_q, byte_last_d;
  logic              pad_err_q, pad_err_d;

  logic [3:0]        width_now;
  logic [3:0]        code_shift;
  logic [7:0]        code_left;
  logic              push, pop, padded, last_pop;
  logic [ACC_W-1:0]  acc_after_pop;
  logic [FILL_W-1:0] fill_after_pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    width_d      = width_q;
    enc_ready_d  = enc_ready_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
    pad_err_d    = 1'b0;

    // The first code of a line uses the live scheme; the rest use the latched width.
    width_now  = (state_q == IDLE) ? decode_width(comp_scheme) : width_q;
    code_shift = 4'd8 - width_now;
    code_left  = (enc_data & (8'hFF >> code_shift)) << code_shift;

    push     = enable & enc_valid & enc_ready_q;
    pop      = enable & (~byte_valid_q | byte_ready) &
               ((fill_q >= FILL_BYTE) | ((state_q == FLUSH) & (fill_q != '0)));
    padded   = pop & (state_q == FLUSH) & (fill_q < FILL_BYTE);
    last_pop = pop & (state_q == FLUSH) & (fill_q <= FILL_BYTE);

    acc_after_pop  = pop ? (acc_q << 8) : acc_q;
    fill_after_pop = pop ? ((fill_q >= FILL_BYTE) ? (fill_q - FILL_BYTE) : '0) : fill_q;

    if (enable && byte_valid_q && byte_ready) begin
      byte_valid_d = 1'b0;
      byte_last_d  = 1'b0;
    end

    if (pop) begin
      // Bits below fill are always zero, so a short residual comes out already padded.
      byte_data_d  = acc_q[ACC_W-1 -: 8];
      byte_valid_d = 1'b1;
      byte_last_d  = last_pop;
      pad_err_d    = padded;
    end

    acc_d  = acc_after_pop;
    fill_d = fill_after_pop;
    if (push) begin
      acc_d  = acc_after_pop | ({code_left, {(ACC_W-8){1'b0}}} >> fill_after_pop);
      fill_d = fill_after_pop + FILL_W'(width_now);
    end

    case (state_q)
      IDLE: begin
        if (push) begin
          width_d = width_now;
          state_d = enc_last ? FLUSH : ACTIVE;
        end
      end
      ACTIVE: begin
        if (push && enc_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (enable && byte_valid_q && byte_ready && byte_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enable) enc_ready_d = (state_d != FLUSH) && (fill_d <= FILL_BYTE);
  end

  always_ff @(posedge sensor_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      fill_q       <= '0;
      width_q      <= 4'd8;
      enc_ready_q  <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      pad_err_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      width_q      <= width_d;
      enc_ready_q  <= enc_ready_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      pad_err_q    <= pad_err_d;
    end
  end

  assign enc_ready  = enc_ready_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;
  assign pad_err    = pad_err_q;

endmodule

// File: tb/tb_csi2tx_comp_byte_packer.sv
// Directed bench for the RAW6/7/8 byte packer; expected bytes come from a
// bit-queue model of the line, checked on every byte transfer.
module tb_csi2tx_comp_byte_packer;

  logic       sensor_clk = 1'b0;
  logic       sys_rst_n;
  logic       enable;
  logic [4:0] comp_scheme;
  logic [7:0] enc_data;
  logic       enc_valid;
  logic       enc_last;
  logic       enc_ready;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       pad_err;

  csi2tx_comp_byte_packer #(.ACC_W(16)) dut (
    .sensor_clk (sensor_clk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .comp_scheme(comp_scheme),
    .enc_data   (enc_data),
    .enc_valid  (enc_valid),
    .enc_last   (enc_last),
    .enc_ready  (enc_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .pad_err    (pad_err)
  );

  always #5 sensor_clk = ~sensor_clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];     // {last, data}
  logic [7:0] line_codes[16];
  int         pad_seen;
  int         pad_exp;
  int         not_ready_cycles;

  logic       hold_prev = 1'b0;
  logic [9:0] hold_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int code_width(input logic [4:0] scheme);
    if (scheme == 5'd2 || scheme == 5'd5) return 7;
    if (scheme == 5'd3 || scheme == 5'd6) return 6;
    return 8;
  endfunction

  // Concatenate the line's codes as a plain bit list, then cut it into bytes.
  task automatic model_line(input int w, input int n, input bit has_last);
    bit bits[$];
    int nbytes;
    logic [7:0] v;
    for (int i = 0; i < n; i++)
      for (int b = w - 1; b >= 0; b--) bits.push_back(line_codes[i][b]);
    nbytes = has_last ? (bits.size() + 7) / 8 : bits.size() / 8;
    for (int k = 0; k < nbytes; k++) begin
      v = '0;
      for (int j = 0; j < 8; j++)
        if (k * 8 + j < bits.size()) v[7-j] = bits[k*8+j];
      exp_q.push_back({(has_last && k == nbytes - 1), v});
    end
    if (has_last && (bits.size() % 8) != 0) pad_exp++;
  endtask

  task automatic tick();
    @(posedge sensor_clk);
    #1;
  endtask

  // Scoreboard and stability monitor, sampled on the falling edge.
  always @(negedge sensor_clk) begin
    if (sys_rst_n) begin
      if (hold_prev) check("hold_stable", {22'd0, byte_valid, byte_last, byte_data}, {22'd0, hold_val});
      if (pad_err) begin
        pad_seen++;
        check("pad_with_last", {30'd0, byte_valid, byte_last}, 32'd3);
      end
      if (enable && byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, required no byte", byte_data);
        end else begin
          check("byte", {23'd0, byte_last, byte_data}, {23'd0, exp_q.pop_front()});
        end
      end
      hold_prev = byte_valid && !(enable && byte_ready);
      hold_val  = {byte_valid, byte_last, byte_data};
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic send_line(input logic [4:0] scheme, input int n, input bit has_last,
                           input int switch_at, input int stall_at, input int bp_at);
    int idx = 0, guard = 0, stall_left = 0, bp_left = 0;
    bit stall_done = 0, bp_done = 0, acc;
    pad_seen = 0;
    pad_exp  = 0;
    not_ready_cycles = 0;
    model_line(code_width(scheme), n, has_last);
    comp_scheme = scheme;
    while (idx < n && guard < 300) begin
      enc_valid = 1'b1;
      enc_data  = line_codes[idx];
      enc_last  = has_last && (idx == n - 1);
      if (idx == stall_at && !stall_done) begin stall_left = 4; stall_done = 1; end
      if (idx == bp_at && !bp_done) begin bp_left = 3; bp_done = 1; end
      enable     = (stall_left == 0);
      byte_ready = (bp_left == 0);
      @(negedge sensor_clk);
      acc = enc_valid && enc_ready && enable;
      if (!enc_ready) not_ready_cycles++;
      if (stall_left > 0) begin
        check("stall_pad_low", {31'd0, pad_err}, 32'd0);
        stall_left--;
      end
      if (bp_left > 0) bp_left--;
      tick();
      if (acc) begin
        idx++;
        if (idx == switch_at) comp_scheme = 5'd4;
      end
      guard++;
    end
    check("accept_budget", {31'd0, idx == n}, 32'd1);
    enc_valid = 1'b0;
    enc_last = 1'b0;
    enable = 1'b1;
    byte_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    check("drain", exp_q.size(), 32'd0);
    tick();
    check("pad_count", pad_seen, pad_exp);
    if (has_last) begin
      @(negedge sensor_clk);
      check("idle_ready", {31'd0, enc_ready}, 32'd1);
      tick();
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    enable = 1'b1;
    comp_scheme = 5'd0;
    enc_data = '0;
    enc_valid = 1'b0;
    enc_last = 1'b0;
    byte_ready = 1'b1;
    repeat (2) @(posedge sensor_clk);
    @(negedge sensor_clk);
    check("rst_outputs", {20'd0, enc_ready, byte_valid, byte_last, pad_err, byte_data}, 32'd0);
    #1 sys_rst_n = 1'b1;
    tick();
    tick();

    // Pin the model against hand-packed bytes before using it on the DUT.
    line_codes[0] = 8'h3F; line_codes[1] = 8'h00; line_codes[2] = 8'h2A; line_codes[3] = 8'h15;
    model_line(6, 4, 1);
    check("pin_raw6_0", {23'd0, exp_q[0]}, 32'h0FC);
    check("pin_raw6_1", {23'd0, exp_q[1]}, 32'h00A);
    check("pin_raw6_2", {23'd0, exp_q[2]}, 32'h195);
    exp_q.delete();
    line_codes[0] = 8'h7F; line_codes[1] = 8'h01; line_codes[2] = 8'h40;
    model_line(7, 3, 1);
    check("pin_raw7_0", {23'd0, exp_q[0]}, 32'h0FE);
    check("pin_raw7_1", {23'd0, exp_q[1]}, 32'h006);
    check("pin_raw7_2", {23'd0, exp_q[2]}, 32'h100);
    exp_q.delete();

    // RAW6 exact line: no padding expected.
    line_codes[0] = 8'h3F; line_codes[1] = 8'h00; line_codes[2] = 8'h2A; line_codes[3] = 8'h15;
    send_line(5'd3, 4, 1, -1, -1, -1);

    // RAW7 padded line with upper-bit junk on one code.
    line_codes[0] = 8'hFF; line_codes[1] = 8'h01; line_codes[2] = 8'h40;
    send_line(5'd5, 3, 1, -1, -1, -1);

    // RAW8 burst with downstream backpressure.
    for (int i = 0; i < 8; i++) line_codes[i] = 8'h11 + 8'(i);
    send_line(5'd4, 8, 1, -1, -1, 3);
    check("enc_ready_dropped", {31'd0, not_ready_cycles != 0}, 32'd1);

    // Scheme switches to RAW8 after the second code; line stays 6-bit.
    line_codes[0] = 8'h3F; line_codes[1] = 8'h01; line_codes[2] = 8'h2A;
    line_codes[3] = 8'h15; line_codes[4] = 8'h33;
    send_line(5'd6, 5, 1, 2, -1, -1);
    line_codes[0] = 8'hA5; line_codes[1] = 8'h5A;
    send_line(5'd4, 2, 1, -1, -1, -1);

    // Enable stall mid-line with enc_valid held.
    line_codes[0] = 8'h12; line_codes[1] = 8'h6D; line_codes[2] = 8'h7F;
    line_codes[3] = 8'h00; line_codes[4] = 8'h55;
    send_line(5'd2, 5, 1, -1, 2, -1);

    // Partial RAW7 line (21 bits, two whole bytes out, five left), then reset.
    line_codes[0] = 8'h55; line_codes[1] = 8'h2A; line_codes[2] = 8'h7F;
    send_line(5'd2, 3, 0, -1, -1, -1);
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_line", {20'd0, enc_ready, byte_valid, byte_last, pad_err, byte_data}, 32'd0);
    exp_q.delete();
    tick();
    sys_rst_n = 1'b1;
    tick();
    tick();
    line_codes[0] = 8'hC3; line_codes[1] = 8'h3C;
    send_line(5'd1, 2, 1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
